// File: rtl/uart_rx_ctrl.sv
// UART RX controller: frame validation, byte FIFO with valid/ready, idle-gated baud updates.
// Optional macro UART_RX_CTRL_ERR_CNT_EN adds the saturating err_cnt output.
module uart_rx_ctrl #(
    parameter int DEPTH    = 8,
    parameter int IDLE_CYC = 5208
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     rx_line,
    input  logic                     rx_done,
    input  logic [7:0]               data_byte,
    input  logic [2:0]               start_cnt,
    input  logic [2:0]               stop_cnt,
    input  logic                     cfg_wr,
    input  logic [2:0]               cfg_baud,
    input  logic                     clr_err,
    output logic [2:0]               baud_set,
    output logic                     baud_pend,
    output logic                     m_valid,
    output logic [7:0]               m_data,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     frame_err,
`ifdef UART_RX_CTRL_ERR_CNT_EN
    output logic                     overrun,
    output logic [7:0]               err_cnt
`else
    output logic                     overrun
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {
        LINE_ACTIVE = 1'b0,
        LINE_IDLE   = 1'b1
    } line_state_e;

    function automatic logic [2:0] clamp_baud(input logic [2:0] code);
        clamp_baud = (code > 3'd4) ? 3'd0 : code;
    endfunction

    function automatic logic frame_good(input logic [2:0] s_cnt, input logic [2:0] p_cnt);
        frame_good = (s_cnt <= 3'd2) && (p_cnt >= 3'd4);
    endfunction

    line_state_e     state_r, state_nxt_s;
    logic            line_idle_s;
    logic [15:0]     idle_cnt_r;
    logic [2:0]      baud_set_r, pend_code_r;
    logic            pend_r;
    logic [7:0]      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r, rd_next_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s, occ_after_pop_s;
    logic            m_valid_r;
    logic [7:0]      m_data_r, head_nxt_s;
    logic            full_s, pop_s, good_s, push_s, drop_s, bad_s;
    logic            frame_err_r, overrun_r;

    // Idle counter: cleared by any low sample, saturates at IDLE_CYC
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            idle_cnt_r <= 16'd0;
        else if (!rx_line)
            idle_cnt_r <= 16'd0;
        else if (idle_cnt_r != 16'(IDLE_CYC))
            idle_cnt_r <= idle_cnt_r + 16'd1;
        else
            idle_cnt_r <= idle_cnt_r;
    end

    // Line FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state_r <= LINE_ACTIVE;
        else
            state_r <= state_nxt_s;
    end

    // Line FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LINE_ACTIVE: if (idle_cnt_r == 16'(IDLE_CYC)) state_nxt_s = LINE_IDLE;
                         else                              state_nxt_s = LINE_ACTIVE;
            LINE_IDLE:   if (!rx_line)                     state_nxt_s = LINE_ACTIVE;
                         else                              state_nxt_s = LINE_IDLE;
            default:     state_nxt_s = LINE_ACTIVE;
        endcase
    end

    // Line FSM outputs
    always_comb begin
        line_idle_s = 1'b0;
        case (state_r)
            LINE_IDLE: line_idle_s = 1'b1;
            default:   line_idle_s = 1'b0;
        endcase
    end

    // Baud control: a fresh write always beats applying the older pending code
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            baud_set_r  <= 3'd0;
            pend_code_r <= 3'd0;
            pend_r      <= 1'b0;
        end else if (cfg_wr) begin
            pend_code_r <= clamp_baud(cfg_baud);
            pend_r      <= 1'b1;
        end else if (pend_r && line_idle_s) begin
            baud_set_r  <= pend_code_r;
            pend_r      <= 1'b0;
        end else begin
            pend_r      <= pend_r;
        end
    end

    // Push/pop decode and next head selection
    always_comb begin
        full_s          = (cnt_r == CW'(DEPTH));
        pop_s           = m_valid_r && m_ready;
        good_s          = frame_good(start_cnt, stop_cnt);
        bad_s           = rx_done && !good_s;
        push_s          = rx_done && good_s && (!full_s || pop_s);
        drop_s          = rx_done && good_s && full_s && !pop_s;
        rd_next_s       = pop_s ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;
        occ_after_pop_s = cnt_r - CW'(pop_s);
        cnt_nxt_s       = cnt_r;
        case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CW'(1'b1);
            2'b01:   cnt_nxt_s = cnt_r - CW'(1'b1);
            default: cnt_nxt_s = cnt_r;
        endcase
        // Bypass the incoming byte when it becomes the head of an otherwise empty queue
        if (occ_after_pop_s != CW'(1'b0))
            head_nxt_s = mem_r[rd_next_s];
        else if (push_s)
            head_nxt_s = data_byte;
        else
            head_nxt_s = m_data_r;
    end

    // FIFO storage; contents need no reset
    always_ff @(posedge clk) begin
        if (push_s)
            mem_r[wr_ptr_r] <= data_byte;
        else
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end

    // FIFO pointers, occupancy and registered head
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            cnt_r     <= '0;
            m_valid_r <= 1'b0;
            m_data_r  <= 8'd0;
        end else begin
            wr_ptr_r  <= push_s ? (wr_ptr_r + AW'(1'b1)) : wr_ptr_r;
            rd_ptr_r  <= rd_next_s;
            cnt_r     <= cnt_nxt_s;
            m_valid_r <= (cnt_nxt_s != CW'(1'b0));
            m_data_r  <= head_nxt_s;
        end
    end

    // Sticky error flags; a new error beats clr_err
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= bad_s  ? 1'b1 : (clr_err ? 1'b0 : frame_err_r);
            overrun_r   <= drop_s ? 1'b1 : (clr_err ? 1'b0 : overrun_r);
        end
    end

`ifdef UART_RX_CTRL_ERR_CNT_EN
    logic [7:0] err_cnt_r;

    // Saturating error counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            err_cnt_r <= 8'd0;
        else if (bad_s || drop_s)
            err_cnt_r <= clr_err ? 8'd1 : ((err_cnt_r == 8'd255) ? err_cnt_r : err_cnt_r + 8'd1);
        else if (clr_err)
            err_cnt_r <= 8'd0;
        else
            err_cnt_r <= err_cnt_r;
    end

    assign err_cnt = err_cnt_r;
`endif

    assign baud_set  = baud_set_r;
    assign baud_pend = pend_r;
    assign m_valid   = m_valid_r;
    assign m_data    = m_data_r;
    assign fifo_cnt  = cnt_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule
